// File: rtl/ccff_chain_loader.sv
// Loads a routing-tile configuration chain from a word stream, LSB first, and can optionally
// rotate the chain once so the CRC of the bits leaving the tail is compared with the CRC taken during load.
module ccff_chain_loader #(
  parameter int          CHAIN_LEN = 8,
  parameter int          WORD_W    = 8,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [WORD_W-1:0] din_data,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int REM_W = $clog2(WORD_W + 1);
  localparam int SUM_W = ((CNT_W > REM_W) ? CNT_W : REM_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  vcnt;
  logic [REM_W-1:0]  rem;
  logic [WORD_W-1:0] sreg;
  logic              head_q;
  logic              shift_q;
  logic              ven_q;
  logic [15:0]       crc_l;
  logic [15:0]       crc_v;
  logic [15:0]       crc_v_n;
  logic [SUM_W-1:0]  committed;
  logic [SUM_W-1:0]  room;
  logic [REM_W-1:0]  take_n;
  logic              accept;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Stream handshake: a word transfers on the prog_clk edge where din_valid and din_ready are both 1;
  // din_valid may drop or data change freely whenever no transfer happens.
  // head_q always presents the bit shifted on the next edge; rem counts it plus the bits still in sreg.
  always_comb begin
    committed = SUM_W'(bit_cnt) + SUM_W'(rem);
    room      = SUM_W'(CHAIN_LEN) - committed;
    din_ready = (state == S_LOAD) && ((rem == '0) || ((rem == REM_W'(1)) && shift_q)) &&
                (committed < SUM_W'(CHAIN_LEN));
    accept    = din_valid && din_ready;
    take_n    = REM_W'(WORD_W);
    if (room < SUM_W'(WORD_W)) take_n = REM_W'(room);
    crc_v_n   = crc_step(crc_v, ccff_tail);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_LOAD;
      S_LOAD: begin
        if (shift_q && (bit_cnt == CNT_W'(CHAIN_LEN - 1))) state_n = ven_q ? S_VERIFY : S_DONE;
      end
      S_VERIFY: begin
        if (vcnt == CNT_W'(CHAIN_LEN - 1)) state_n = (crc_v_n == crc_l) ? S_DONE : S_ERROR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      vcnt    <= '0;
      rem     <= '0;
      sreg    <= '0;
      head_q  <= 1'b0;
      shift_q <= 1'b0;
      ven_q   <= 1'b0;
      crc_l   <= CRC_INIT;
      crc_v   <= CRC_INIT;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            ven_q   <= verify_en;
            bit_cnt <= '0;
            vcnt    <= '0;
            rem     <= '0;
            head_q  <= 1'b0;
            shift_q <= 1'b0;
            crc_l   <= CRC_INIT;
            crc_v   <= CRC_INIT;
          end
        end
        S_LOAD: begin
          if (shift_q) begin
            crc_l <= crc_step(crc_l, head_q);
            if (bit_cnt != CNT_W'(CHAIN_LEN)) bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (accept) begin
            head_q  <= din_data[0];
            sreg    <= din_data >> 1;
            rem     <= take_n;
            shift_q <= 1'b1;
          end else if (rem > REM_W'(1)) begin
            head_q <= sreg[0];
            sreg   <= sreg >> 1;
            rem    <= rem - REM_W'(1);
          end else begin
            head_q  <= 1'b0;
            shift_q <= 1'b0;
            rem     <= '0;
          end
        end
        S_VERIFY: begin
          crc_v <= crc_v_n;
          vcnt  <= vcnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // During verify the tail is fed straight back to the head; the tail is a flop, so no loop forms.
  always_comb begin
    ccff_shift_en = shift_q || (state == S_VERIFY);
    ccff_head     = (state == S_VERIFY) ? ccff_tail : head_q;
    busy          = (state == S_LOAD) || (state == S_VERIFY);
    done          = (state == S_DONE);
    error         = (state == S_ERROR);
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Drives three loaders (chains of 8, 16 and 11 flops) against a behavioural chain model and
// checks head order, timing, final chain contents and verify results.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       prog_rst_n;
  logic       start[3];
  logic       verify_en[3];
  logic       din_valid[3];
  logic [7:0] din_data[3];
  logic       din_ready[3];
  logic       ccff_tail[3];
  logic       ccff_head[3];
  logic       ccff_shift_en[3];
  logic       busy[3];
  logic       done[3];
  logic       error[3];

  logic [15:0] chain[3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] flip_mask[3];
  logic        cap_bits[3][0:8191];
  int          cap_n[3] = '{0, 0, 0};
  logic [7:0]  word_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 prog_clk = ~prog_clk;

  function automatic int len_of(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 16 : 11);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    ccff_chain_loader #(
      .CHAIN_LEN((g == 0) ? 8 : ((g == 1) ? 16 : 11)),
      .WORD_W   (8),
      .CRC_INIT (16'hFFFF)
    ) u_dut (
      .prog_clk     (prog_clk),
      .prog_rst_n   (prog_rst_n),
      .start        (start[g]),
      .verify_en    (verify_en[g]),
      .din_valid    (din_valid[g]),
      .din_ready    (din_ready[g]),
      .din_data     (din_data[g]),
      .ccff_tail    (ccff_tail[g]),
      .ccff_head    (ccff_head[g]),
      .ccff_shift_en(ccff_shift_en[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .error        (error[g])
    );
    assign ccff_tail[g] = chain[g][0];
  end

  // Chain model: head enters at bit len-1, tail is bit 0; flip_mask injects a corruption.
  function automatic logic [15:0] chain_next(input logic [15:0] c, input logic [15:0] m,
                                             input logic en, input logic h, input int len);
    logic [15:0] x;
    x = c ^ m;
    if (en) x = (x >> 1) | (16'(h) << (len - 1));
    return x;
  endfunction

  always @(posedge prog_clk) begin
    for (int g = 0; g < 3; g++) begin
      chain[g] <= chain_next(chain[g], flip_mask[g], ccff_shift_en[g], ccff_head[g], len_of(g));
      if (ccff_shift_en[g]) begin
        if (cap_n[g] < 8192) cap_bits[g][cap_n[g]] <= ccff_head[g];
        cap_n[g] <= cap_n[g] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse(input int g, input bit ven);
    @(negedge prog_clk);
    start[g] = 1'b1;
    verify_en[g] = ven;
    @(negedge prog_clk);
    start[g] = 1'b0;
    verify_en[g] = 1'b0;
  endtask

  task automatic send_word(input int g, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    din_valid[g] = 1'b1;
    din_data[g] = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (din_ready[g]) ok = 1'b1;
      else @(negedge prog_clk);
    end
    if (ok) @(posedge prog_clk);
    #1;
    din_valid[g] = 1'b0;
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_end(input int g, output int cyc);
    cyc = 0;
    while (!(done[g] || error[g]) && cyc < 300) begin
      @(negedge prog_clk);
      cyc++;
    end
    check("end_timeout", 32'(cyc < 300), 32'd1);
  endtask

  task automatic wait_shifts(input int g, input int base, input int n);
    int cyc;
    cyc = 0;
    while ((cap_n[g] - base) < n && cyc < 300) begin
      @(negedge prog_clk);
      cyc++;
    end
    check("shift_wait_timeout", 32'(cyc < 300), 32'd1);
  endtask

  // Expected result built from word_q: stream bits LSB-first, keep the first len bits.
  task automatic check_run(input int g, input bit ven, input bit exp_err, input int base,
                           input logic [15:0] flip, input string tag);
    int          len;
    int          nexp;
    bit          bits_q[$];
    logic [15:0] ec;
    logic [31:0] exp_seq;
    logic [31:0] obs_seq;
    len = len_of(g);
    nexp = ven ? 2 * len : len;
    ec = '0;
    exp_seq = '0;
    obs_seq = '0;
    foreach (word_q[w]) for (int b = 0; b < 8; b++) bits_q.push_back(word_q[w][b]);
    for (int i = 0; i < len; i++) ec[i] = bits_q[i];
    for (int i = 0; i < len; i++) exp_seq[i] = ec[i];
    if (ven) for (int i = 0; i < len; i++) exp_seq[len + i] = ec[i] ^ flip[i];
    for (int i = 0; i < nexp; i++) obs_seq[i] = cap_bits[g][base + i];
    check({tag, "_nshift"}, 32'(cap_n[g] - base), 32'(nexp));
    check({tag, "_head_seq"}, obs_seq, exp_seq);
    check({tag, "_chain"}, 32'(chain[g]), 32'(ec ^ flip));
    check({tag, "_done_err"}, {30'd0, done[g], error[g]}, {30'd0, !exp_err, exp_err});
    check({tag, "_busy"}, 32'(busy[g]), 32'd0);
  endtask

  initial begin
    int base;
    int cyc;
    int g;
    bit ven;
    prog_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      verify_en[i] = 1'b0;
      din_valid[i] = 1'b0;
      din_data[i] = 8'h00;
      flip_mask[i] = 16'h0;
    end
    repeat (3) @(posedge prog_clk);
    #1;
    for (int i = 0; i < 3; i++)
      check("reset_outputs",
            {26'd0, din_ready[i], ccff_head[i], ccff_shift_en[i], busy[i], done[i], error[i]}, 32'd0);
    @(negedge prog_clk);
    prog_rst_n = 1'b1;

    // T1: plain load of 0xA5, latency and done timing
    word_q = '{8'hA5};
    base = cap_n[0];
    start_pulse(0, 1'b0);
    check("t1_ready_in_load", 32'(din_ready[0]), 32'd1);
    send_word(0, 8'hA5);
    check("t1_first_bit", {30'd0, ccff_shift_en[0], ccff_head[0]}, 32'd3);
    wait_end(0, cyc);
    check("t1_done_latency", 32'(cyc), 32'd9);
    check_run(0, 1'b0, 1'b0, base, 16'h0, "t1");
    check("t1_chain_const", 32'(chain[0]), 32'h00A5);

    // T2: load plus verify
    base = cap_n[0];
    start_pulse(0, 1'b1);
    send_word(0, 8'hA5);
    wait_end(0, cyc);
    check_run(0, 1'b1, 1'b0, base, 16'h0, "t2");
    check("t2_chain_const", 32'(chain[0]), 32'h00A5);

    // T3: corrupt chain bit 3 once load completes
    base = cap_n[0];
    start_pulse(0, 1'b1);
    send_word(0, 8'hA5);
    wait_shifts(0, base, 8);
    flip_mask[0] = 16'h0008;
    @(negedge prog_clk);
    flip_mask[0] = 16'h0;
    wait_end(0, cyc);
    check_run(0, 1'b1, 1'b1, base, 16'h0008, "t3");
    word_q = '{8'h3C};
    base = cap_n[0];
    start_pulse(0, 1'b0);
    check("t3_restart_clears", {29'd0, error[0], done[0], busy[0]}, 32'd1);
    send_word(0, 8'h3C);
    wait_end(0, cyc);
    check_run(0, 1'b0, 1'b0, base, 16'h0, "t3b");

    // T4: stream stall between words on the 16-bit chain; a start while busy is ignored
    word_q = '{8'h3C, 8'hF0};
    base = cap_n[1];
    start_pulse(1, 1'b0);
    send_word(1, 8'h3C);
    repeat (10) @(negedge prog_clk);
    check("t4_stall_shift_en", {30'd0, ccff_shift_en[1], busy[1]}, 32'd1);
    start_pulse(1, 1'b1);
    check("t4_stall_nshift", 32'(cap_n[1] - base), 32'd8);
    send_word(1, 8'hF0);
    wait_end(1, cyc);
    check_run(1, 1'b0, 1'b0, base, 16'h0, "t4");
    check("t4_chain_const", 32'(chain[1]), 32'hF03C);

    // T5: 11-bit chain discards the high bits of the last word
    word_q = '{8'hFF, 8'h02};
    base = cap_n[2];
    start_pulse(2, 1'b0);
    send_word(2, 8'hFF);
    send_word(2, 8'h02);
    check("t5_ready_after_last", {30'd0, din_ready[2], busy[2]}, 32'd1);
    wait_end(2, cyc);
    check_run(2, 1'b0, 1'b0, base, 16'h0, "t5");
    check("t5_chain_const", 32'(chain[2]), 32'h02FF);

    // T6: reset in the middle of a load, then reload
    base = cap_n[0];
    start_pulse(0, 1'b0);
    send_word(0, 8'h77);
    wait_shifts(0, base, 4);
    prog_rst_n = 1'b0;
    #1;
    check("t6_reset_outputs",
          {26'd0, din_ready[0], ccff_head[0], ccff_shift_en[0], busy[0], done[0], error[0]}, 32'd0);
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    word_q = '{8'h5A};
    base = cap_n[0];
    start_pulse(0, 1'b0);
    send_word(0, 8'h5A);
    wait_end(0, cyc);
    check_run(0, 1'b0, 1'b0, base, 16'h0, "t6");

    // Randomised loads across all chain lengths with random gaps and verify passes
    for (int r = 0; r < 30; r++) begin
      g = $urandom_range(0, 2);
      ven = 1'($urandom_range(0, 1));
      word_q = {};
      for (int w = 0; w < (len_of(g) + 7) / 8; w++) word_q.push_back(8'($urandom));
      base = cap_n[g];
      start_pulse(g, ven);
      foreach (word_q[w]) begin
        repeat ($urandom_range(0, 3)) @(negedge prog_clk);
        send_word(g, word_q[w]);
      end
      wait_end(g, cyc);
      check_run(g, ven, 1'b0, base, 16'h0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
